scan_display_driver: RTL and testbench
======================================

SCAN_DISPLAY_DRIVER -- requirements
Module: scan_display_driver

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of multiplexed 7-segment digits; legal range 1..8.
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles per digit slot; legal range 2..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: scan enable.
REQ-006 The block SHALL have port blank_en, input, 1 bit: leading-zero blanking enable.
REQ-007 The block SHALL have port digits_in, input, 4*DIGITS bits: BCD digits from upstream mod-N counters; nibble 0 (bits 3:0) is least significant.
REQ-008 The block SHALL have port seg, output, 7 bits: registered segments {g,f,e,d,c,b,a}, active-high.
REQ-009 The block SHALL have port an, output, DIGITS bits: registered digit enables, active-low, at most one bit low.
REQ-010 The block SHALL have port frame_done, output, 1 bit: registered one-cycle pulse at the end of each full scan frame.

Function
REQ-011 The prescaler SHALL count 0..SCAN_DIV-1 while en=1; tick is true when prescaler = SCAN_DIV-1 and en=1; on tick the prescaler returns to 0.
REQ-012 The digit index SHALL advance by 1 on each tick and wrap from DIGITS-1 to 0.
REQ-013 On the tick where the index wraps to 0, the snapshot register SHALL capture digits_in; changes on digits_in at any other time SHALL NOT affect the display until the next wrap (no tearing).
REQ-014 frame_done SHALL be 1 in the cycle after the wrapping tick and 0 otherwise.
REQ-015 Each cycle, an and seg SHALL be registered from the current index and snapshot, so outputs follow an index change with one cycle of latency.
REQ-016 an SHALL drive bit[index] low and all other bits high when en=1.
REQ-017 Decode SHALL be 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; nibble values 10..15 SHALL display 0x40 ("-").
REQ-018 With blank_en=1, digit i>0 SHALL show seg=0x00 when snapshot nibbles i..DIGITS-1 are all 0; digit 0 SHALL never be blanked; an is unaffected by blanking.
REQ-019 With en=0, prescaler and index SHALL hold, an SHALL be all ones, seg SHALL be 0x00, frame_done SHALL be 0; on re-enable, scanning SHALL resume from the held prescaler and index.
REQ-020 With DIGITS=1, every tick SHALL be a wrap: snapshot captured and frame_done pulsed each tick.

Reset
REQ-021 While rst_n=0, regardless of clk: prescaler=0, index=0, snapshot=0, seg=0x00, an=all ones, frame_done=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately; after release, the first tick SHALL occur SCAN_DIV enabled cycles later.

Structure
REQ-023 A shared package SHALL hold the BCD nibble width constant (4), the ten segment codes, the invalid code 0x40 and the blank code 0x00.
REQ-024 The BCD-to-segment decode SHALL be a separate combinational sub-module named bcd_to_seg7; the prescaler, index, snapshot and output registers SHALL stay in scan_display_driver.

Verification
REQ-025 DIGITS=4, SCAN_DIV=4, en=1, blank_en=0, digits_in=0x1234 held -> frame 1 shows 0x00 digits (0x3F on each an); from frame 2 the outputs cycle an=1110/seg=0x66, 1101/0x4F, 1011/0x5B, 0111/0x06, each held 4 cycles; frame_done pulses every 16 cycles.
REQ-026 blank_en=1, snapshot 0x0050 -> digit3 and digit2 seg=0x00, digit1 seg=0x6D, digit0 seg=0x3F; snapshot 0x0000 -> only digit0 shows 0x3F.
REQ-027 digits_in changed from 0x1234 to 0x9876 while index=1 -> remainder of the frame still shows 1234; the next frame shows 9876.
REQ-028 Nibble 0xC at digit2 -> seg=0x40 in digit2's slot.
REQ-029 en dropped for 10 cycles while index=2 and prescaler=1 -> an=1111 and seg=0x00 throughout; after en=1, index 2 completes its remaining 3 cycles, then index 3.
REQ-030 rst_n pulsed low between clock edges mid-frame -> outputs take reset values immediately; first tick occurs 4 cycles after release.

Source files
------------

// File: rtl/scan_display_driver_pkg.sv
// ---------------------------------------------------------------------------
// scan_display_driver_pkg : shared constants for the multiplexed 7-seg driver
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package scan_display_driver_pkg;

  localparam int BCD_W      = 4;   // width of one BCD nibble
  localparam int MAX_DIGITS = 8;   // largest supported DIGITS value
  localparam int IDX_W      = 3;   // holds any digit index 0..MAX_DIGITS-1
  localparam int PRE_W      = 16;  // holds any prescaler value 0..65534

  typedef logic [6:0] seg_t;       // {g,f,e,d,c,b,a}, active-high

  localparam seg_t SEG_0       = 7'h3F;
  localparam seg_t SEG_1       = 7'h06;
  localparam seg_t SEG_2       = 7'h5B;
  localparam seg_t SEG_3       = 7'h4F;
  localparam seg_t SEG_4       = 7'h66;
  localparam seg_t SEG_5       = 7'h6D;
  localparam seg_t SEG_6       = 7'h7D;
  localparam seg_t SEG_7       = 7'h07;
  localparam seg_t SEG_8       = 7'h7F;
  localparam seg_t SEG_9       = 7'h6F;
  localparam seg_t SEG_INVALID = 7'h40;
  localparam seg_t SEG_BLANK   = 7'h00;

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7 : combinational BCD nibble to 7-segment decode with blanking
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_to_seg7
  import scan_display_driver_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_INVALID;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_INVALID;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/scan_display_driver.sv
// ---------------------------------------------------------------------------
// scan_display_driver : time-multiplexed scanner for DIGITS 7-segment digits
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module scan_display_driver
  import scan_display_driver_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    blank_en,
  input  logic [BCD_W*DIGITS-1:0] digits_in,
  output logic [6:0]              seg,
  output logic [DIGITS-1:0]       an,
  output logic                    frame_done
);

  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        index;
  logic [BCD_W*DIGITS-1:0] snapshot;

  logic [BCD_W-1:0]        nib [MAX_DIGITS];
  logic [MAX_DIGITS-1:1]   zero_from;
  logic [MAX_DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]       an_next;
  logic [6:0]              dec_seg;
  logic                    tick;
  logic                    wrap;

  // Pad the nibble array to MAX_DIGITS so the 3-bit index never goes out of range.
  for (genvar i = 0; i < MAX_DIGITS; i++) begin : g_nib
    if (i < DIGITS) begin : g_real
      assign nib[i] = snapshot[i*BCD_W +: BCD_W];
    end else begin : g_pad
      assign nib[i] = '0;
    end
  end

  // zero_from[i]: snapshot nibbles i..top are all zero (leading-zero run).
  for (genvar i = 1; i < MAX_DIGITS; i++) begin : g_zero
    if (i == MAX_DIGITS - 1) begin : g_top
      assign zero_from[i] = (nib[i] == '0);
    end else begin : g_chain
      assign zero_from[i] = (nib[i] == '0) && zero_from[i+1];
    end
  end

  for (genvar i = 0; i < MAX_DIGITS; i++) begin : g_blank
    if (i == 0) begin : g_lsd
      assign blank_mask[i] = 1'b0;
    end else begin : g_upper
      assign blank_mask[i] = zero_from[i];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_an
    assign an_next[i] = (index != IDX_W'(i));
  end

  bcd_to_seg7 u_dec (
    .bcd   (nib[index]),
    .blank (blank_en && blank_mask[index]),
    .seg   (dec_seg)
  );

  assign tick = en && (presc == PRE_W'(SCAN_DIV - 1));
  assign wrap = tick && (index == IDX_W'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      index      <= '0;
      snapshot   <= '0;
      seg        <= SEG_BLANK;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (en) begin
        an  <= an_next;
        seg <= dec_seg;
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
      end
      if (tick) begin
        presc <= '0;
        if (wrap) begin
          index    <= '0;
          snapshot <= digits_in;
        end else begin
          index <= index + 1'b1;
        end
      end else if (en) begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scan_display_driver.sv
// ---------------------------------------------------------------------------
// tb_scan_display_driver : randomized check of scan_display_driver vs a model
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_scan_display_driver;

  localparam int D     = 4;
  localparam int SD    = 4;
  localparam int FRAME = D * SD;

  localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          blank_en;
  logic [4*D-1:0] digits_in;
  logic [6:0]    seg;
  logic [D-1:0]  an;
  logic          frame_done;

  int            tests = 0;
  int            fails = 0;
  int            ecount;       // enabled cycles since reset release
  logic [4*D-1:0] snap;
  logic [6:0]    exp_seg;
  logic [D-1:0]  exp_an;
  logic          exp_fd;

  always #5 clk = ~clk;

  scan_display_driver #(
    .DIGITS   (D),
    .SCAN_DIV (SD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .blank_en   (blank_en),
    .digits_in  (digits_in),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input logic [4*D-1:0] s, input int i, input bit blank);
    int v;
    v = int'((s >> (4 * i)) & 16'hF);
    if (blank && i > 0 && (s >> (4 * i)) == 0) return 7'h00;
    if (v > 9) return 7'h40;
    return CODES[v];
  endfunction

  function automatic logic [4*D-1:0] rand_digits();
    logic [4*D-1:0] d;
    int r;
    d = '0;
    for (int k = 0; k < D; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      d[4*k +: 4] = 4'd0;
      else if (r == 4) d[4*k +: 4] = 4'($urandom_range(10, 15));
      else             d[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return d;
  endfunction

  // Outputs after an edge depend on the slot reached so far and the pre-edge inputs.
  task automatic predict();
    int idx;
    bit wrap;
    idx  = (ecount / SD) % D;
    wrap = en && ((ecount + 1) % FRAME == 0);
    exp_an  = en ? ~(D'(1) << idx) : '1;
    exp_seg = en ? model_seg(snap, idx, blank_en) : 7'h00;
    exp_fd  = wrap;
    if (wrap) snap = digits_in;
    if (en) ecount++;
  endtask

  task automatic cycle(input bit rnd);
    @(posedge clk);
    predict();
    @(negedge clk);
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    if (rnd) begin
      en       = ($urandom_range(0, 9) != 0);
      blank_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) digits_in = rand_digits();
    end
  endtask

  task automatic reset_model();
    ecount = 0;
    snap   = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    blank_en  = 1'b0;
    digits_in = '0;
    reset_model();
    repeat (2) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);

    rst_n     = 1'b1;
    en        = 1'b1;
    digits_in = 16'h1234;
    repeat (40) cycle(1'b0);
    repeat (600) cycle(1'b1);

    // Asynchronous reset dropped between edges with scanning active.
    en = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h0);
    check("async_rst_fd", 32'(frame_done), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("held_rst_an", 32'(an), 32'hF);
    rst_n = 1'b1;
    reset_model();
    repeat (600) cycle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
